// File: rtl/prbs9_checker.sv
// PRBS9 (x^9+x^5+1) serial stream checker with self-sync, lock tracking,
// error pulse and saturating error/bit counters for BER measurement.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   enable    bit_in is valid this cycle; all state advances only when high
//   bit_in    received serial bit
//   clear     synchronous clear of err_count and bit_count
//   locked    high while the local reference is locked to the stream
//   err_pulse one-cycle pulse per mismatched bit while locked
//   err_count saturating count of mismatches while locked
//   bit_count saturating count of bits compared while locked
module prbs9_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [8:0]    sr;
    logic [8:0]    st;
    logic [3:0]    fill;
    logic [GW-1:0] good;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    logic [8:0]    sr_next;
    logic          fill_done;
    logic          match;
    logic          lock_hit;
    logic          expected;
    logic          mismatch;
    logic [EW-1:0] win_err_next;
    logic          unlock_hit;
    logic          win_last;

    always_comb begin
        sr_next      = {sr[7:0], bit_in};
        fill_done    = (fill == 4'd9);
        // A correct prediction only counts toward lock if the register
        // is not all-zero; otherwise a dead line would look like PRBS.
        match        = fill_done && (bit_in == (sr[8] ^ sr[4]))
                       && (sr_next != 9'd0);
        lock_hit     = match && (good == GW'(LOCK_COUNT - 1));
        expected     = st[8] ^ st[4];
        mismatch     = (bit_in != expected);
        win_err_next = win_err + EW'(mismatch);
        unlock_hit   = mismatch && (win_err_next >= EW'(UNLOCK_ERRS));
        win_last     = (win_cnt == WW'(WIN_LEN - 1));
        state_next   = state;
        unique case (state)
            SEARCH: if (enable && lock_hit) state_next = LOCKED;
            LOCKED: if (enable && unlock_hit) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_next;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            st        <= '0;
            fill      <= '0;
            good      <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (enable) begin
                if (state == SEARCH) begin
                    sr <= sr_next;
                    if (!fill_done) begin
                        fill <= fill + 4'd1;
                    end else if (lock_hit) begin
                        good    <= '0;
                        st      <= sr_next;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else if (match) begin
                        good <= good + GW'(1);
                    end else begin
                        good <= '0;
                    end
                end else begin
                    // Free-running reference: never reloaded from bit_in,
                    // so one line error yields exactly one mismatch.
                    st <= {st[7:0], expected};
                    if (bit_count != '1) bit_count <= bit_count + 1'b1;
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                    end
                    if (unlock_hit) begin
                        sr      <= '0;
                        fill    <= '0;
                        good    <= '0;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                        win_err <= win_err_next;
                    end
                end
            end
            if (clear) begin
                err_count <= '0;
                bit_count <= '0;
            end
        end
    end

endmodule
